alocador_vozes: RTL and testbench

ALOCADOR_VOZES -- requirements
Module: alocador_vozes

---
 rtl/alocador_vozes_pkg.sv | 27 ++
 rtl/alocador_vozes_sinc.sv | 26 ++
 rtl/alocador_vozes.sv | 160 ++++++++++++++++
 tb/tb_alocador_vozes.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alocador_vozes_pkg.sv
// Shared constants for the voice allocator: half-period table, idle value and slot classes.
package pkg_synth;

    localparam int unsigned CP_W   = 18;
    localparam int unsigned NR_LUT = 10;

    localparam logic [CP_W-1:0] CP_INATIVO = 18'h3FFFF;

    localparam logic [CP_W-1:0] CP_LUT [NR_LUT] = '{
        18'd143172, 18'd135139, 18'd127551, 18'd120394, 18'd113636,
        18'd107262, 18'd101239, 18'd95557,  18'd90192,  18'd85131
    };

    typedef enum logic [1:0] {
        SlotNop,
        SlotPress,
        SlotRelease
    } slot_e;

    // Keys beyond the table reuse the highest entry.
    function automatic logic [CP_W-1:0] cp_da_tecla(input logic [3:0] k);
        logic [3:0] idx;
        idx = (k < 4'(NR_LUT)) ? k : 4'(NR_LUT - 1);
        return CP_LUT[idx];
    endfunction

endpackage

// File: rtl/alocador_vozes_sinc.sv
// Two-flop synchroniser bringing the raw key levels into the clk domain.
module sincronizador_teclas #(
    parameter int unsigned LARGURA = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] d_i,
    output logic [LARGURA-1:0] q_o
);

    logic [LARGURA-1:0] s1_q;
    logic [LARGURA-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/alocador_vozes.sv
// Scans one key per cycle and assigns pressed keys to free oscillator voices.
// Define ALOCADOR_ROUBO_EN to let a fresh press steal the oldest voice when all are busy.
module alocador_vozes
    import pkg_synth::*;
#(
    parameter int unsigned NR_TECLAS = 10,
    parameter int unsigned NR_VOZES  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NR_TECLAS-1:0]           teclas,
    output logic [NR_VOZES-1:0]            voz_ativa,
    output logic [NR_VOZES-1:0][CP_W-1:0]  voz_cp,
    output logic [NR_VOZES-1:0][3:0]       voz_tecla,
    output logic                           cheio
);

    localparam int unsigned VW = 3;

    logic [NR_TECLAS-1:0] teclas_sinc;
    logic [15:0]          teclas_ext;

    logic [3:0]                     k_q, k_d;
    logic [NR_VOZES-1:0]            ativa_q, ativa_d;
    logic [NR_VOZES-1:0][CP_W-1:0]  cp_q, cp_d;
    logic [NR_VOZES-1:0][3:0]       tecla_q, tecla_d;
    logic                           cheio_q, cheio_d;

    logic          chave;
    logic          dono_valido, livre_valido;
    logic [VW-1:0] dono, livre;
    logic          aloca;
    logic [VW-1:0] alvo;
    slot_e         slot;

    sincronizador_teclas #(
        .LARGURA (NR_TECLAS)
    ) u_sinc (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (teclas),
        .q_o   (teclas_sinc)
    );

    assign teclas_ext = 16'(teclas_sinc);

    always_comb begin
        chave        = teclas_ext[k_q];
        dono_valido  = 1'b0;
        dono         = '0;
        livre_valido = 1'b0;
        livre        = '0;
        for (int v = 0; v < NR_VOZES; v++) begin
            if (ativa_q[v] && tecla_q[v] == k_q && !dono_valido) begin
                dono_valido = 1'b1;
                dono        = VW'(v);
            end
            if (!ativa_q[v] && !livre_valido) begin
                livre_valido = 1'b1;
                livre        = VW'(v);
            end
        end
        if (chave && !dono_valido) begin
            slot = SlotPress;
        end else if (!chave && dono_valido) begin
            slot = SlotRelease;
        end else begin
            slot = SlotNop;
        end
    end

`ifdef ALOCADOR_ROUBO_EN
    logic [NR_VOZES-1:0][3:0] idade_q, idade_d;
    logic [15:0]              visto_q, visto_d;
    logic [VW-1:0]            velho;
    logic [3:0]               maior;

    // Only a fresh press may steal; a key already seen held waits for a free voice.
    always_comb begin
        maior = idade_q[0];
        velho = '0;
        for (int v = 1; v < NR_VOZES; v++) begin
            if (idade_q[v] > maior) begin
                maior = idade_q[v];
                velho = VW'(v);
            end
        end
        aloca          = (slot == SlotPress) && (livre_valido || !visto_q[k_q]);
        alvo           = livre_valido ? livre : velho;
        visto_d        = visto_q;
        visto_d[k_q]   = chave;
        idade_d        = idade_q;
        if (aloca) begin
            for (int v = 0; v < NR_VOZES; v++) begin
                if (alvo == VW'(v)) begin
                    idade_d[v] = '0;
                end else if (ativa_q[v] && idade_q[v] != 4'd15) begin
                    idade_d[v] = idade_q[v] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idade_q <= '0;
            visto_q <= '0;
        end else begin
            idade_q <= idade_d;
            visto_q <= visto_d;
        end
    end
`else
    always_comb begin
        aloca = (slot == SlotPress) && livre_valido;
        alvo  = livre;
    end
`endif

    always_comb begin
        k_d     = (k_q == 4'(NR_TECLAS - 1)) ? 4'd0 : k_q + 4'd1;
        ativa_d = ativa_q;
        cp_d    = cp_q;
        tecla_d = tecla_q;
        for (int v = 0; v < NR_VOZES; v++) begin
            if (slot == SlotRelease && dono == VW'(v)) begin
                ativa_d[v] = 1'b0;
                cp_d[v]    = CP_INATIVO;
            end
            if (aloca && alvo == VW'(v)) begin
                ativa_d[v] = 1'b1;
                tecla_d[v] = k_q;
                cp_d[v]    = cp_da_tecla(k_q);
            end
        end
        cheio_d = &ativa_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            ativa_q <= '0;
            cp_q    <= {NR_VOZES{CP_INATIVO}};
            tecla_q <= '0;
            cheio_q <= 1'b0;
        end else begin
            k_q     <= k_d;
            ativa_q <= ativa_d;
            cp_q    <= cp_d;
            tecla_q <= tecla_d;
            cheio_q <= cheio_d;
        end
    end

    assign voz_ativa = ativa_q;
    assign voz_cp    = cp_q;
    assign voz_tecla = tecla_q;
    assign cheio     = cheio_q;

endmodule

// File: tb/tb_alocador_vozes.sv
// Directed bench for alocador_vozes: reset, press/release, full polyphony, mid-scan reset, glitches.
module tb_alocador_vozes;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [9:0]       teclas;
    logic [3:0]       voz_ativa;
    logic [3:0][17:0] voz_cp;
    logic [3:0][3:0]  voz_tecla;
    logic             cheio;

    int vetores = 0;
    int erros   = 0;

    localparam logic [17:0] INATIVO = 18'h3FFFF;

    alocador_vozes #(
        .NR_TECLAS (10),
        .NR_VOZES  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .teclas    (teclas),
        .voz_ativa (voz_ativa),
        .voz_cp    (voz_cp),
        .voz_tecla (voz_tecla),
        .cheio     (cheio)
    );

    always #5 clk = ~clk;

    // No key may ever be owned by two active voices.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = i + 1; j < 4; j++) begin
                    if (voz_ativa[i] && voz_ativa[j] && voz_tecla[i] == voz_tecla[j]) begin
                        $display("FAIL dup_owner: voices %0d,%0d both own key %0d", i, j,
                                 voz_tecla[i]);
                        erros++;
                    end
                end
            end
        end
    end

    task automatic esperar(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reiniciar();
        @(negedge clk);
        rst_n  = 1'b0;
        teclas = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        vetores++;
        if (voz_ativa !== 4'h0) begin
            $display("FAIL reset_ativa: got %h want 0", voz_ativa); erros++;
        end
        vetores++;
        if (cheio !== 1'b0) begin
            $display("FAIL reset_cheio: got %b want 0", cheio); erros++;
        end
        for (int v = 0; v < 4; v++) begin
            vetores++;
            if (voz_cp[v] !== INATIVO) begin
                $display("FAIL reset_cp%0d: got %h want %h", v, voz_cp[v], INATIVO); erros++;
            end
            vetores++;
            if (voz_tecla[v] !== 4'd0) begin
                $display("FAIL reset_tecla%0d: got %0d want 0", v, voz_tecla[v]); erros++;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_press_release();
        teclas = 10'h008;
        esperar(12);
        vetores++;
        if (voz_ativa !== 4'b0001) begin
            $display("FAIL pr_ativa: got %b want 0001", voz_ativa); erros++;
        end
        vetores++;
        if (voz_tecla[0] !== 4'd3) begin
            $display("FAIL pr_tecla: got %0d want 3", voz_tecla[0]); erros++;
        end
        vetores++;
        if (voz_cp[0] !== 18'd120394) begin
            $display("FAIL pr_cp: got %0d want 120394", voz_cp[0]); erros++;
        end
        teclas = 10'h000;
        esperar(12);
        vetores++;
        if (voz_ativa !== 4'b0000) begin
            $display("FAIL rel_ativa: got %b want 0000", voz_ativa); erros++;
        end
        vetores++;
        if (voz_cp[0] !== INATIVO) begin
            $display("FAIL rel_cp: got %h want %h", voz_cp[0], INATIVO); erros++;
        end
        vetores++;
        if (voz_tecla[0] !== 4'd3) begin
            $display("FAIL rel_tecla: got %0d want 3", voz_tecla[0]); erros++;
        end
    endtask

    task automatic pressionar_0_a_3();
        for (int i = 0; i < 4; i++) begin
            teclas[i] = 1'b1;
            esperar(12);
        end
    endtask

    task automatic test_four_keys();
        logic [17:0] cp_ref [4];
        cp_ref = '{18'd143172, 18'd135139, 18'd127551, 18'd120394};
        reiniciar();
        pressionar_0_a_3();
        vetores++;
        if (voz_ativa !== 4'hF || cheio !== 1'b1) begin
            $display("FAIL four_full: got ativa=%b cheio=%b want 1111/1", voz_ativa, cheio);
            erros++;
        end
        for (int v = 0; v < 4; v++) begin
            vetores++;
            if (voz_tecla[v] !== 4'(v) || voz_cp[v] !== cp_ref[v]) begin
                $display("FAIL four_v%0d: got key %0d cp %0d want key %0d cp %0d", v,
                         voz_tecla[v], voz_cp[v], v, cp_ref[v]);
                erros++;
            end
        end
        teclas[1] = 1'b0;
        esperar(12);
        vetores++;
        if (voz_ativa !== 4'b1101 || cheio !== 1'b0) begin
            $display("FAIL four_rel1: got ativa=%b cheio=%b want 1101/0", voz_ativa, cheio);
            erros++;
        end
        vetores++;
        if (voz_cp[1] !== INATIVO) begin
            $display("FAIL four_rel1_cp: got %h want %h", voz_cp[1], INATIVO); erros++;
        end
    endtask

    task automatic test_full_press();
        reiniciar();
        pressionar_0_a_3();
        teclas[9] = 1'b1;
        esperar(12);
`ifdef ALOCADOR_ROUBO_EN
        vetores++;
        if (voz_tecla[0] !== 4'd9 || voz_cp[0] !== 18'd85131) begin
            $display("FAIL steal: got key %0d cp %0d want key 9 cp 85131", voz_tecla[0],
                     voz_cp[0]);
            erros++;
        end
        esperar(25);
        for (int v = 1; v < 4; v++) begin
            vetores++;
            if (voz_tecla[v] !== 4'(v)) begin
                $display("FAIL steal_keep%0d: got %0d want %0d", v, voz_tecla[v], v); erros++;
            end
        end
        vetores++;
        if (voz_tecla[0] !== 4'd9 || voz_ativa !== 4'hF) begin
            $display("FAIL steal_hold: got key %0d ativa %b want 9/1111", voz_tecla[0],
                     voz_ativa);
            erros++;
        end
`else
        vetores++;
        if (voz_tecla[0] !== 4'd0 || voz_cp[0] !== 18'd143172 || voz_ativa !== 4'hF) begin
            $display("FAIL full_ignore: got key %0d cp %0d ativa %b want 0/143172/1111",
                     voz_tecla[0], voz_cp[0], voz_ativa);
            erros++;
        end
        teclas[2] = 1'b0;
        esperar(22);
        vetores++;
        if (voz_tecla[2] !== 4'd9 || voz_cp[2] !== 18'd85131) begin
            $display("FAIL full_retry: got key %0d cp %0d want key 9 cp 85131", voz_tecla[2],
                     voz_cp[2]);
            erros++;
        end
        vetores++;
        if (voz_ativa !== 4'hF || cheio !== 1'b1) begin
            $display("FAIL full_retry_cheio: got ativa=%b cheio=%b want 1111/1", voz_ativa,
                     cheio);
            erros++;
        end
`endif
    endtask

    task automatic test_reset_mid();
        reiniciar();
        teclas = 10'h060;
        esperar(12);
        vetores++;
        if (voz_ativa !== 4'b0011 || voz_tecla[0] !== 4'd5 || voz_tecla[1] !== 4'd6) begin
            $display("FAIL mid_pre: got ativa %b keys %0d,%0d want 0011 5,6", voz_ativa,
                     voz_tecla[0], voz_tecla[1]);
            erros++;
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vetores++;
        if (voz_ativa !== 4'h0 || cheio !== 1'b0 || voz_cp !== {4{INATIVO}} || voz_tecla !== 16'h0)
        begin
            $display("FAIL mid_async: got ativa %b cheio %b keys %h", voz_ativa, cheio,
                     voz_tecla);
            erros++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        esperar(12);
        vetores++;
        if (voz_ativa !== 4'b0011 || voz_tecla[0] !== 4'd5 || voz_tecla[1] !== 4'd6) begin
            $display("FAIL mid_post: got ativa %b keys %0d,%0d want 0011 5,6", voz_ativa,
                     voz_tecla[0], voz_tecla[1]);
            erros++;
        end
        teclas = '0;
    endtask

    task automatic test_glitch();
        // Glitch before edge 3 reaches the scan at edge 5 (slot 4): key 7 is missed.
        reiniciar();
        repeat (2) @(posedge clk);
        @(negedge clk);
        teclas[7] = 1'b1;
        @(negedge clk);
        teclas[7] = 1'b0;
        esperar(20);
        vetores++;
        if (voz_ativa !== 4'h0) begin
            $display("FAIL glitch_miss: got %b want 0000", voz_ativa); erros++;
        end
        // Glitch before edge 6 is evaluated at edge 8, exactly slot 7.
        reiniciar();
        repeat (5) @(posedge clk);
        @(negedge clk);
        teclas[7] = 1'b1;
        @(negedge clk);
        teclas[7] = 1'b0;
        esperar(2);
        vetores++;
        if (voz_ativa !== 4'b0001 || voz_tecla[0] !== 4'd7 || voz_cp[0] !== 18'd95557) begin
            $display("FAIL glitch_hit: got ativa %b key %0d cp %0d want 0001/7/95557",
                     voz_ativa, voz_tecla[0], voz_cp[0]);
            erros++;
        end
        esperar(10);
        vetores++;
        if (voz_ativa !== 4'h0 || voz_cp[0] !== INATIVO) begin
            $display("FAIL glitch_free: got ativa %b cp %h want 0000/%h", voz_ativa,
                     voz_cp[0], INATIVO);
            erros++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        teclas = '0;
        #12;
        test_reset();
        test_press_release();
        test_four_keys();
        test_full_press();
        test_reset_mid();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
